fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction fetch stage that sits directly downstream of the program counter logic and upstream of decode. It owns the fetch address and issues in-order word requests to instruction memory. It buffers returned instructions with their PCs in a small queue and presents them to decode over a valid/ready handshake. On a branch/jump redirect it flushes buffered and in-flight fetches and restarts from the redirect target.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
DEPTH, 2, instruction queue entries; also the credit limit on outstanding + buffered fetches (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
redirect_valid  input  1  branch/jump taken; restart fetch this cycle
redirect_pc  input  32  redirect target; bits [1:0] forced to 0
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response valid; in order, latency >=1 cycle, cannot be stalled
imem_rsp_data  input  32  returned instruction word
dec_valid  output  1  instruction available for decode
dec_ready  input  1  decode accepts instruction
dec_pc  output  32  PC of the head instruction
dec_instr  output  32  head instruction word

Behaviour:
- State: fetch_pc (32b); outstanding count; drop count; queue of {pc, instr} entries (DEPTH); PC tag FIFO for in-flight requests (DEPTH). Counters are $clog2(DEPTH+1) bits wide.
- Reset (async): fetch_pc=RESET_PC; all counts, queue and tag FIFO empty. Outputs during and after reset: imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_pc=0, dec_instr=0.
- Credit: imem_req_valid=1 iff outstanding + drop + queue_count < DEPTH and redirect_valid=0. imem_req_addr=fetch_pc.
- Request fire (valid&&ready): push fetch_pc into the tag FIFO, outstanding++, fetch_pc += 4 (wraps mod 2^32).
- Response handling:
  - If drop>0, discard the response and decrement drop.
  - Otherwise pop the tag FIFO, write {tag, imem_rsp_data} into the queue and decrement outstanding. The credit rule guarantees space.
  - A response with outstanding==0 and drop==0 is ignored.
- Decode handshake: dec_valid = (queue_count>0) && !redirect_valid. dec_pc and dec_instr show the head entry; they hold their last value when the queue is empty. The queue pops on dec_valid&&dec_ready. Zero-cycle bypass is not allowed: a response reaches dec_valid no earlier than the next cycle. Simultaneous push and pop at full or empty is legal and the count is unchanged.
- Redirect (registered at the clock edge in which redirect_valid=1):
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - The queue and tag FIFO are flushed.
  - drop <= drop + outstanding, minus 1 if a response arrives in the same cycle.
  - outstanding <= 0.
  - No request and no decode pop occur that cycle.
  - New requests may issue the following cycle if credit allows.
  - Back-to-back redirects: the last one wins; drop accumulates correctly.
- Throughput: with single-cycle memory and dec_ready=1, one instruction per cycle is sustained after 2-cycle initial latency (request at cycle 0, dec_valid at cycle 2).
- Memory must be reset with this block; responses to pre-reset requests are not allowed.

Test Plan:
- Reset release, 1-cycle memory, dec_ready=1: imem_req_addr steps 0x0, 0x4, 0x8…; dec_pc 0x0 at cycle 2, then one instruction per cycle with matching dec_instr.
- Hold dec_ready=0 with DEPTH=2: exactly 2 requests fire, then imem_req_valid=0 while the queue is full. Raise dec_ready: PCs 0x0, 0x4 are delivered in order and fetch resumes at 0x8.
- 3-cycle memory latency with 2 requests in flight, then redirect_valid with redirect_pc=0x103: both late responses are dropped, the next request address is 0x100, and the first dec_pc is 0x100.
- Redirect in the same cycle as a response arrival and with dec_valid high: no pop occurs, drop accounts for the arriving response, and the queue is empty next cycle.
- imem_req_ready toggled randomly: no duplicate or skipped PCs, and every dec_instr matches the model memory at dec_pc.
- Assert rst mid-stream with a full queue: all outputs return to reset values immediately, and fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch between the PC logic and decode.
//   Owns the fetch address and issues in-order word requests to instruction
//   memory. Returned words are paired with their PCs and held in a DEPTH-entry
//   queue for decode. A redirect flushes everything and restarts at the target.
//
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   redirect_valid, redirect_pc      taken branch/jump and its target
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data              in-order, unstallable response channel
//   dec_valid/ready, dec_pc/instr    decode handshake and head instruction
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    cnt_t        outst_q, outst_d;
    cnt_t        drop_q, drop_d;
    cnt_t        qcnt_q, qcnt_d;
    ptr_t        qhead_q, qhead_d, qtail_q, qtail_d;
    ptr_t        thead_q, thead_d, ttail_q, ttail_d;
    logic [31:0] dec_pc_q, dec_pc_d;
    logic [31:0] dec_instr_q, dec_instr_d;

    // Storage arrays carry no reset; occupancy is tracked by the counters.
    logic [31:0] q_pc_q    [DEPTH];
    logic [31:0] q_instr_q [DEPTH];
    logic [31:0] tag_q     [DEPTH];

    logic        req_fire, rsp_take, rsp_drop, pop;
    logic [CW+1:0] in_use;
    logic [CW:0]   pend_sum;
    logic          redir_lsb_unused;

    assign redir_lsb_unused = ^redirect_pc[1:0];

    always_comb begin
        in_use = (CW + 2)'(outst_q) + (CW + 2)'(drop_q) + (CW + 2)'(qcnt_q);
        // rst gating keeps the request line low while reset is asserted.
        imem_req_valid = !rst && (in_use < DEPTH_W) && !redirect_valid;
        imem_req_addr  = fetch_pc_q;
        dec_valid      = (qcnt_q != '0) && !redirect_valid;
        dec_pc         = dec_pc_q;
        dec_instr      = dec_instr_q;

        req_fire = imem_req_valid && imem_req_ready;
        pop      = dec_valid && dec_ready;
        rsp_drop = imem_rsp_valid && (drop_q != '0);
        rsp_take = imem_rsp_valid && (drop_q == '0) && (outst_q != '0) && !redirect_valid;
        pend_sum = (CW + 1)'(drop_q) + (CW + 1)'(outst_q);

        fetch_pc_d  = fetch_pc_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        qcnt_d      = qcnt_q;
        qhead_d     = qhead_q;
        qtail_d     = qtail_q;
        thead_d     = thead_q;
        ttail_d     = ttail_q;
        dec_pc_d    = dec_pc_q;
        dec_instr_d = dec_instr_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            // Everything still owed by memory becomes a drop; a response
            // arriving now settles one of them immediately.
            if (imem_rsp_valid && (pend_sum != '0)) begin
                drop_d = cnt_t'(pend_sum - (CW + 1)'(1));
            end else begin
                drop_d = cnt_t'(pend_sum);
            end
            outst_d = '0;
            qcnt_d  = '0;
            qhead_d = '0;
            qtail_d = '0;
            thead_d = '0;
            ttail_d = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                ttail_d    = ttail_q + ptr_t'(1);
            end
            if (rsp_drop) begin
                drop_d = drop_q - cnt_t'(1);
            end
            if (rsp_take) begin
                thead_d = thead_q + ptr_t'(1);
                qtail_d = qtail_q + ptr_t'(1);
            end
            if (pop) begin
                qhead_d = qhead_q + ptr_t'(1);
            end
            outst_d = outst_q + cnt_t'(req_fire) - cnt_t'(rsp_take);
            qcnt_d  = qcnt_q + cnt_t'(rsp_take) - cnt_t'(pop);
        end

        // Output registers track the next head so the displayed entry holds
        // its last value once the queue drains or is flushed.
        if (qcnt_d != '0) begin
            if (rsp_take && (qtail_q == qhead_d)) begin
                dec_pc_d    = tag_q[thead_q];
                dec_instr_d = imem_rsp_data;
            end else begin
                dec_pc_d    = q_pc_q[qhead_d];
                dec_instr_d = q_instr_q[qhead_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            outst_q     <= '0;
            drop_q      <= '0;
            qcnt_q      <= '0;
            qhead_q     <= '0;
            qtail_q     <= '0;
            thead_q     <= '0;
            ttail_q     <= '0;
            dec_pc_q    <= '0;
            dec_instr_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            qcnt_q      <= qcnt_d;
            qhead_q     <= qhead_d;
            qtail_q     <= qtail_d;
            thead_q     <= thead_d;
            ttail_q     <= ttail_d;
            dec_pc_q    <= dec_pc_d;
            dec_instr_q <= dec_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[ttail_q] <= fetch_pc_q;
        end
        if (rsp_take) begin
            q_pc_q[qtail_q]    <= tag_q[thead_q];
            q_instr_q[qtail_q] <= imem_rsp_data;
        end
    end

endmodule
